seq_vote_machine: RTL and testbench

- Clocked, parametrised N-voter ballot engine. It generalises the team's combinational four-input vote machine.
- `start` opens a voting session. Each voter may cast exactly one ballot, asynchronously to the others.
- The session closes when all voters have cast or when a timeout expires. The block then reports yes/no tallies and pass/tie/timeout flags.
- Sits between per-voter input strobes and the result/display logic.

---
 rtl/seq_vote_machine.sv | 174 +++++++++++++++++
 tb/tb_seq_vote_machine.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_vote_machine.sv
// Clocked N-voter ballot engine: a session opens on start, accepts one ballot per
// voter until everyone has voted or the timer expires, then reports tallies and flags.
module seq_vote_machine #(
    parameter  int N_VOTERS = 4,
    parameter  int TIMEOUT  = 255,
    parameter  int MODE     = 0,
    localparam int CW       = $clog2(N_VOTERS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [N_VOTERS-1:0] cast,
    input  logic [N_VOTERS-1:0] ballot,
    output logic                busy,
    output logic [N_VOTERS-1:0] voted,
    output logic [CW-1:0]       yes_cnt,
    output logic [CW-1:0]       no_cnt,
    output logic                done,
    output logic                pass,
    output logic                tie,
    output logic                timed_out
);

    // Timer counts 0..TIMEOUT-1 inside OPEN.
    localparam int          TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [CW:0]   N_EXT      = (CW + 1)'(N_VOTERS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OPEN  = 2'd1,
        S_TALLY = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [N_VOTERS-1:0]   r_voted;
    logic [CW-1:0]         r_yes;
    logic [CW-1:0]         r_no;
    logic [TW-1:0]         r_timer;
    logic                  r_pass;
    logic                  r_tie;
    logic                  r_timed_out;
    logic                  r_done;

    logic [N_VOTERS-1:0]   w_accepted;
    logic [N_VOTERS-1:0]   w_voted_nxt;
    logic [CW-1:0]         w_yes_nxt;
    logic [CW-1:0]         w_no_nxt;
    logic                  w_all_voted;
    logic                  w_timer_last;
    logic                  w_load;
    logic                  w_in_open;
    logic                  w_in_tally;
    logic                  w_pass;
    logic                  w_tie;

    function automatic logic [CW-1:0] popcount(input logic [N_VOTERS-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < N_VOTERS; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    // Ballot acceptance: only the first cast per voter in a session counts.
    assign w_accepted   = cast & ~r_voted;
    assign w_voted_nxt  = r_voted | w_accepted;
    assign w_yes_nxt    = r_yes + popcount(w_accepted & ballot);
    assign w_no_nxt     = r_no + popcount(w_accepted & ~ballot);
    assign w_all_voted  = &w_voted_nxt;
    assign w_timer_last = (r_timer == TIMER_LAST);

    // Result compare in CW+1 bits so 2*yes never wraps.
    always_comb begin
        w_pass = 1'b0;
        w_tie  = 1'b0;
        if (MODE == 1) begin
            w_pass = ({r_yes, 1'b0} > N_EXT);
            w_tie  = ({r_yes, 1'b0} == N_EXT);
        end else begin
            w_pass = ({1'b0, r_yes} > {1'b0, r_no});
            w_tie  = ({1'b0, r_yes} == {1'b0, r_no});
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: a default assignment at the top of every always_comb keeps
    // synthesis from inferring latches on paths that don't assign.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_OPEN;
            S_OPEN:  if (w_all_voted || w_timer_last) w_state_nxt = S_TALLY;
            S_TALLY: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        w_load     = 1'b0;
        w_in_open  = 1'b0;
        w_in_tally = 1'b0;
        case (r_state)
            S_IDLE:  w_load     = start;
            S_OPEN:  begin busy = 1'b1; w_in_open  = 1'b1; end
            S_TALLY: begin busy = 1'b1; w_in_tally = 1'b1; end
            default: busy       = 1'b0;
        endcase
    end

    // NOTE: every datapath register is plain flops (no memory arrays), so all
    // of it is reset; rst_n alone must leave the outputs at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_voted     <= '0;
            r_yes       <= '0;
            r_no        <= '0;
            r_timer     <= '0;
            r_pass      <= 1'b0;
            r_tie       <= 1'b0;
            r_timed_out <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_in_tally;
            if (w_load) begin
                r_voted     <= '0;
                r_yes       <= '0;
                r_no        <= '0;
                r_timer     <= '0;
                r_pass      <= 1'b0;
                r_tie       <= 1'b0;
                r_timed_out <= 1'b0;
            end
            if (w_in_open) begin
                r_voted <= w_voted_nxt;
                r_yes   <= w_yes_nxt;
                r_no    <= w_no_nxt;
                if (w_all_voted) begin
                    r_timed_out <= 1'b0;
                end else if (w_timer_last) begin
                    r_timed_out <= 1'b1;
                end else begin
                    r_timer <= r_timer + TW'(1);
                end
            end
            if (w_in_tally) begin
                r_pass <= w_pass;
                r_tie  <= w_tie;
            end
        end
    end

    assign voted     = r_voted;
    assign yes_cnt   = r_yes;
    assign no_cnt    = r_no;
    assign done      = r_done;
    assign pass      = r_pass;
    assign tie       = r_tie;
    assign timed_out = r_timed_out;

endmodule

// File: tb/tb_seq_vote_machine.sv
// Directed bench for seq_vote_machine: three instances (MODE0/T255, MODE0/T8, MODE1/T8)
// share ballot inputs, each with its own start.
module tb_seq_vote_machine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_a, start_b, start_c;
    logic [3:0] cast, ballot;

    logic       busy_a, done_a, pass_a, tie_a, to_a;
    logic       busy_b, done_b, pass_b, tie_b, to_b;
    logic       busy_c, done_c, pass_c, tie_c, to_c;
    logic [3:0] voted_a, voted_b, voted_c;
    logic [2:0] yes_a, no_a, yes_b, no_b, yes_c, no_c;

    int n_checks = 0;
    int n_fail   = 0;

    // Result word: {done, busy, yes[2:0], no[2:0], pass, tie, timed_out}
    wire [10:0] res_a = {done_a, busy_a, yes_a, no_a, pass_a, tie_a, to_a};
    wire [10:0] res_b = {done_b, busy_b, yes_b, no_b, pass_b, tie_b, to_b};
    wire [10:0] res_c = {done_c, busy_c, yes_c, no_c, pass_c, tie_c, to_c};

    always #5 clk = ~clk;

    seq_vote_machine #(.N_VOTERS(4), .TIMEOUT(255), .MODE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .cast(cast), .ballot(ballot),
        .busy(busy_a), .voted(voted_a), .yes_cnt(yes_a), .no_cnt(no_a),
        .done(done_a), .pass(pass_a), .tie(tie_a), .timed_out(to_a)
    );
    seq_vote_machine #(.N_VOTERS(4), .TIMEOUT(8), .MODE(0)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .cast(cast), .ballot(ballot),
        .busy(busy_b), .voted(voted_b), .yes_cnt(yes_b), .no_cnt(no_b),
        .done(done_b), .pass(pass_b), .tie(tie_b), .timed_out(to_b)
    );
    seq_vote_machine #(.N_VOTERS(4), .TIMEOUT(8), .MODE(1)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .cast(cast), .ballot(ballot),
        .busy(busy_c), .voted(voted_c), .yes_cnt(yes_c), .no_cnt(no_c),
        .done(done_c), .pass(pass_c), .tie(tie_c), .timed_out(to_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] exp_res(input logic d, input logic b, input logic [2:0] y,
                                            input logic [2:0] n, input logic p, input logic t,
                                            input logic to);
        return {d, b, y, n, p, t, to};
    endfunction

    task automatic test_reset();
        #2;
        n_checks++;
        if ({res_a, res_b, res_c, voted_a, voted_b, voted_c} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got a=%h b=%h c=%h voted=%h/%h/%h want all zero",
                     res_a, res_b, res_c, voted_a, voted_b, voted_c);
        end
    endtask

    task automatic test_basic();
        start_a = 1'b1;
        tick();
        start_a = 1'b0; cast = 4'b0111; ballot = 4'b0111;
        tick();
        n_checks++;
        if (res_a !== exp_res(0, 1, 3, 0, 0, 0, 0)) begin
            n_fail++; $display("FAIL basic_cycle1 got %h want %h", res_a, exp_res(0, 1, 3, 0, 0, 0, 0));
        end
        cast = 4'b1000; ballot = 4'b0000;
        tick();
        cast = 4'b0000;
        n_checks++;
        if (res_a !== exp_res(0, 1, 3, 1, 0, 0, 0)) begin
            n_fail++; $display("FAIL basic_tally got %h want %h", res_a, exp_res(0, 1, 3, 1, 0, 0, 0));
        end
        tick();
        n_checks++;
        if (res_a !== exp_res(1, 0, 3, 1, 1, 0, 0) || voted_a !== 4'b1111) begin
            n_fail++; $display("FAIL basic_done got %h voted %b want %h voted 1111",
                               res_a, voted_a, exp_res(1, 0, 3, 1, 1, 0, 0));
        end
        tick();
        n_checks++;
        if (res_a !== exp_res(0, 0, 3, 1, 1, 0, 0)) begin
            n_fail++; $display("FAIL basic_hold got %h want %h", res_a, exp_res(0, 0, 3, 1, 1, 0, 0));
        end
    endtask

    task automatic test_duplicate();
        start_a = 1'b1;
        tick();
        start_a = 1'b0; cast = 4'b0001; ballot = 4'b0001;
        tick();
        cast = 4'b0000; start_a = 1'b1;   // start while OPEN must be ignored
        tick();
        start_a = 1'b0; cast = 4'b0001; ballot = 4'b0000;
        tick();
        n_checks++;
        if (res_a !== exp_res(0, 1, 1, 0, 0, 0, 0) || voted_a !== 4'b0001) begin
            n_fail++; $display("FAIL dup_ignored got %h voted %b want %h voted 0001",
                               res_a, voted_a, exp_res(0, 1, 1, 0, 0, 0, 0));
        end
        cast = 4'b1110; ballot = 4'b1110;
        tick();
        cast = 4'b0000;
        tick();
        n_checks++;
        if (res_a !== exp_res(1, 0, 4, 0, 1, 0, 0) || voted_a !== 4'b1111) begin
            n_fail++; $display("FAIL dup_result got %h voted %b want %h voted 1111",
                               res_a, voted_a, exp_res(1, 0, 4, 0, 1, 0, 0));
        end
        tick();
    endtask

    task automatic test_timeout();
        start_b = 1'b1; start_c = 1'b1;
        tick();
        start_b = 1'b0; start_c = 1'b0; cast = 4'b0011; ballot = 4'b0001;
        tick();
        cast = 4'b0000;
        repeat (6) tick();
        n_checks++;
        if ({busy_b, done_b, busy_c, done_c} !== 4'b1010) begin
            n_fail++; $display("FAIL timeout_open7 got %b want 1010", {busy_b, done_b, busy_c, done_c});
        end
        tick();
        n_checks++;
        if (res_b !== exp_res(0, 1, 1, 1, 0, 0, 1)) begin
            n_fail++; $display("FAIL timeout_tally got %h want %h", res_b, exp_res(0, 1, 1, 1, 0, 0, 1));
        end
        tick();
        n_checks++;
        if (res_b !== exp_res(1, 0, 1, 1, 0, 1, 1)) begin
            n_fail++; $display("FAIL timeout_mode0 got %h want %h", res_b, exp_res(1, 0, 1, 1, 0, 1, 1));
        end
        n_checks++;
        if (res_c !== exp_res(1, 0, 1, 1, 0, 0, 1)) begin
            n_fail++; $display("FAIL timeout_mode1 got %h want %h", res_c, exp_res(1, 0, 1, 1, 0, 0, 1));
        end
        tick();
    endtask

    task automatic test_simultaneous();
        start_a = 1'b1; start_b = 1'b1; start_c = 1'b1;
        tick();
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        cast = 4'b1111; ballot = 4'b1010;
        tick();
        cast = 4'b0000;
        tick();
        n_checks++;
        if ({res_a, res_b, res_c} !== {3{exp_res(1, 0, 2, 2, 0, 1, 0)}}) begin
            n_fail++; $display("FAIL simultaneous got a=%h b=%h c=%h want %h",
                               res_a, res_b, res_c, exp_res(1, 0, 2, 2, 0, 1, 0));
        end
        tick();
    endtask

    task automatic test_reset_mid();
        start_a = 1'b1;
        tick();
        start_a = 1'b0; cast = 4'b0011; ballot = 4'b0001;
        tick();
        cast = 4'b0000;
        n_checks++;
        if (res_a !== exp_res(0, 1, 1, 1, 0, 0, 0)) begin
            n_fail++; $display("FAIL rstmid_pre got %h want %h", res_a, exp_res(0, 1, 1, 1, 0, 0, 0));
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({res_a, voted_a} !== '0) begin
            n_fail++; $display("FAIL rstmid_async got %h voted %b want 0", res_a, voted_a);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({res_a, voted_a} !== '0) begin
            n_fail++; $display("FAIL rstmid_no_done got %h voted %b want 0", res_a, voted_a);
        end
        test_basic();
    endtask

    task automatic test_back_to_back();
        logic [2:0] y;
        logic       p, t;
        start_a = 1'b1; start_b = 1'b1; start_c = 1'b1;
        for (int pat = 0; pat < 16; pat++) begin
            tick();
            start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
            n_checks++;
            if ({busy_a, busy_b, busy_c, yes_a, no_a, yes_c, no_c} !== 15'b111_000_000_000_000) begin
                n_fail++; $display("FAIL b2b_open pat=%0d busy=%b%b%b yes/no a=%0d/%0d c=%0d/%0d want busy 111 zero",
                                   pat, busy_a, busy_b, busy_c, yes_a, no_a, yes_c, no_c);
            end
            cast = 4'b1111; ballot = 4'(pat);
            tick();
            cast = 4'b0000;
            tick();
            y = 3'($countones(4'(pat)));
            p = (y >= 3'd3);
            t = (y == 3'd2);
            n_checks++;
            if ({res_a, res_b, res_c} !== {3{exp_res(1, 0, y, 3'd4 - y, p, t, 0)}}) begin
                n_fail++; $display("FAIL b2b_result pat=%0d got a=%h b=%h c=%h want %h",
                                   pat, res_a, res_b, res_c, exp_res(1, 0, y, 3'd4 - y, p, t, 0));
            end
            if (pat < 15) begin
                start_a = 1'b1; start_b = 1'b1; start_c = 1'b1;
            end
        end
        tick();
        n_checks++;
        if ({busy_a, busy_b, busy_c, done_a, done_b, done_c} !== 6'b0) begin
            n_fail++; $display("FAIL b2b_idle got busy=%b%b%b done=%b%b%b want 0",
                               busy_a, busy_b, busy_c, done_a, done_b, done_c);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        cast = 4'b0000; ballot = 4'b0000;
        test_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        test_basic();
        test_duplicate();
        test_timeout();
        test_simultaneous();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
